// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter: FSM encoding and
// counter sizing helper.
package piso_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : int'($clog2(n));
    return w;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift register; o_bit is the bit at the outgoing end.
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load has priority; shifting moves the next bit toward the outgoing end.
  always_comb begin
    data_d = data_q;
    if (i_load) begin
      data_d = i_data;
    end else if (i_shift) begin
      data_d = LSB_FIRST ? (data_q >> 1) : (data_q << 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_bit = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit per clock on o_q
// with frame/last strobes and an optional idle gap between words.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter int unsigned GAP        = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_q,
  output logic             o_frame,
  output logic             o_last,
  output logic             o_busy
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned GW = cnt_width(GAP + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP == 0) ? 0 : GAP - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          q_q, q_d;
  logic          frame_q, frame_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;

  logic             ready_c;
  logic             accept_c;
  logic             load_c;
  logic             shift_c;
  logic             first_bit_c;
  logic [WIDTH-1:0] rest_c;
  logic             sr_bit;

  assign ready_c  = i_rst_n & ((state_q == ST_IDLE) |
                               ((state_q == ST_SHIFT) & (cnt_q == '0) & (GAP == 0)));
  assign accept_c = i_valid & ready_c;

  // The first bit goes straight to o_q; the register holds the remaining bits so its
  // outgoing bit is always the one to drive on the next shift.
  assign first_bit_c = LSB_FIRST ? i_data[0] : i_data[WIDTH-1];
  assign rest_c      = LSB_FIRST ? (i_data >> 1) : (i_data << 1);

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load_c),
    .i_shift (shift_c),
    .i_data  (rest_c),
    .o_bit   (sr_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    q_d     = q_q;
    frame_d = frame_q;
    load_c  = 1'b0;
    shift_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          load_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          shift_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
          q_d     = sr_bit;
        end else if (accept_c) begin
          load_c = 1'b1;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          gcnt_d  = GAP_INIT;
          q_d     = IDLE_LEVEL;
          frame_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          q_d     = IDLE_LEVEL;
          frame_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        q_d     = IDLE_LEVEL;
        frame_d = 1'b0;
      end
    endcase

    // A new word starts the same way from IDLE or straight after a final bit.
    if (load_c) begin
      state_d = ST_SHIFT;
      cnt_d   = CNT_INIT;
      q_d     = first_bit_c;
      frame_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
    last_d = (state_d == ST_SHIFT) && (cnt_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      q_q     <= IDLE_LEVEL;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      q_q     <= q_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready = ready_c;
  assign o_q     = q_q;
  assign o_frame = frame_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three instances (default, LSB-first, no gap) with a
// scoreboard of expected {bit,last} pairs popped whenever o_frame is high.
module tb_piso_serial_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] data  [3];
  logic       valid [3];
  logic       ready [3];
  logic       q     [3];
  logic       frame [3];
  logic       last  [3];
  logic       busy  [3];

  int vecs = 0;
  int errs = 0;

  logic [1:0] exp0[$];
  logic [1:0] exp1[$];
  logic [1:0] exp2[$];

  always #5 clk = ~clk;

  piso_serial_tx u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_q(q[0]), .o_frame(frame[0]), .o_last(last[0]), .o_busy(busy[0])
  );

  piso_serial_tx #(.LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_q(q[1]), .o_frame(frame[1]), .o_last(last[1]), .o_busy(busy[1])
  );

  piso_serial_tx #(.GAP(0)) u_g0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_q(q[2]), .o_frame(frame[2]), .o_last(last[2]), .o_busy(busy[2])
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bit(input int k, input logic b, input logic l);
    case (k)
      0:       exp0.push_back({b, l});
      1:       exp1.push_back({b, l});
      default: exp2.push_back({b, l});
    endcase
  endtask

  // seq is the hand-written wire order, leftmost bit first; last flags the final one.
  task automatic push_word(input int k, input logic [3:0] seq);
    for (int i = 3; i >= 0; i--) begin
      push_bit(k, seq[i], 1'(i == 0));
    end
  endtask

  task automatic mon(input int k, input logic f, input logic qq, input logic ll);
    logic [1:0] e;
    bit         have;
    e    = 2'b00;
    have = 1'b0;
    if (f) begin
      case (k)
        0:       if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
        1:       if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
        default: if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        vecs++;
        errs++;
        $display("FAIL dut%0d unexpected bit: got q=%b last=%b expected no frame at %0t",
                 k, qq, ll, $time);
      end else begin
        chk1($sformatf("dut%0d bit", k), qq, e[1]);
        chk1($sformatf("dut%0d last", k), ll, e[0]);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, frame[0], q[0], last[0]);
    mon(1, frame[1], q[1], last[1]);
    mon(2, frame[2], q[2], last[2]);
  end

  // Returns #1 after the accept edge, i.e. inside the cycle carrying the first bit.
  task automatic send(input int k, input logic [3:0] d);
    int n;
    n = 0;
    @(negedge clk);
    data[k]  = d;
    valid[k] = 1'b1;
    while (!ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vecs++;
      errs++;
      $display("FAIL dut%0d send timeout: got ready=0 expected ready=1 within 50 cycles", k);
    end
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      data[k]  = 4'h0;
      valid[k] = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("dut%0d reset ready", k), ready[k], 1'b0);
      chk1($sformatf("dut%0d reset frame", k), frame[k], 1'b0);
      chk1($sformatf("dut%0d reset q", k), q[k], 1'b0);
      chk1($sformatf("dut%0d reset busy", k), busy[k], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk1($sformatf("dut%0d ready after reset", k), ready[k], 1'b1);

    // Default instance, 4'b1011 MSB first, one gap cycle.
    push_word(0, 4'b1011);
    send(0, 4'b1011);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk1($sformatf("t2 frame c%0d", c), frame[0], 1'b1);
        chk1($sformatf("t2 ready c%0d", c), ready[0], 1'b0);
        chk1($sformatf("t2 busy c%0d", c), busy[0], 1'b1);
      end else if (c == 5) begin
        chk1("t2 gap frame", frame[0], 1'b0);
        chk1("t2 gap q", q[0], 1'b0);
        chk1("t2 gap ready", ready[0], 1'b0);
        chk1("t2 gap busy", busy[0], 1'b1);
      end else begin
        chk1("t2 ready after gap", ready[0], 1'b1);
        chk1("t2 idle busy", busy[0], 1'b0);
      end
    end

    // LSB-first instance: 4'b1011 goes out as 1,1,0,1.
    push_word(1, 4'b1101);
    send(1, 4'b1011);
    repeat (6) @(negedge clk);

    // No-gap instance: 4'hA then 4'h5 back to back with valid held.
    push_word(2, 4'b1010);
    push_word(2, 4'b0101);
    @(negedge clk);
    data[2]  = 4'hA;
    valid[2] = 1'b1;
    chk1("t4 ready idle", ready[2], 1'b1);
    @(posedge clk);
    #1;
    data[2] = 4'h5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1($sformatf("t4 frame c%0d", i + 1), frame[2], 1'b1);
      if (i == 3) chk1("t4 ready on last bit", ready[2], 1'b1);
      if (i == 4) valid[2] = 1'b0;
    end
    @(negedge clk);
    chk1("t4 frame after", frame[2], 1'b0);
    chk1("t4 ready after", ready[2], 1'b1);

    // Reset two bits into 4'hF; the rest of that word must never appear.
    push_bit(0, 1'b1, 1'b0);
    push_bit(0, 1'b1, 1'b0);
    send(0, 4'hF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk1("t5 third bit before reset", q[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t5 reset q", q[0], 1'b0);
    chk1("t5 reset frame", frame[0], 1'b0);
    chk1("t5 reset ready", ready[0], 1'b0);
    chk1("t5 reset busy", busy[0], 1'b0);
    chk1("t5 reset last", last[0], 1'b0);
    repeat (2) @(negedge clk);
    chk1("t5 held frame", frame[0], 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("t5 ready after release", ready[0], 1'b1);
    push_word(0, 4'b1001);
    send(0, 4'h9);
    repeat (6) @(negedge clk);

    // Input churn while busy must not disturb the word in flight.
    push_word(0, 4'b0110);
    push_word(0, 4'b1100);
    send(0, 4'h6);
    valid[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      data[0] = (i % 2 == 1) ? 4'h3 : 4'hA;
      if (i == 5) data[0] = 4'hC;
      chk1($sformatf("t6 ready busy c%0d", i), ready[0], 1'b0);
    end
    @(negedge clk);
    chk1("t6 ready first free cycle", ready[0], 1'b1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (7) @(negedge clk);

    chk1("dut0 queue drained", 1'(exp0.size() == 0), 1'b1);
    chk1("dut1 queue drained", 1'(exp1.size() == 0), 1'b1);
    chk1("dut2 queue drained", 1'(exp2.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
